// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler and its arbiter.
package uart_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_e;

    // Datapath bit time in clk cycles (5.76 MHz / 115200 baud)
    localparam int CLKS_PER_BIT  = 50;
    // Frame bit indices as driven on TX_Bit_sel: 9 = start bit, 0 = stop bit
    localparam int BIT_IDX_START = 9;
    localparam int BIT_IDX_STOP  = 0;

    // Round-robin pointer advance: the requester after g, wrapping at n-1
    function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
        logic [2:0] nxt;
        if (int'(g) >= n - 1) begin
            nxt = 3'd0;
        end else begin
            nxt = g + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping from N_REQ-1 back to 0. Purely combinational.
module uart_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [2:0]       grant_idx_o,
    output logic             any_o
);

    logic [3:0]       cand;
    logic [N_REQ-1:0] req_sh;

    // Scan requesters starting at the pointer; the first hit wins
    always_comb begin
        grant_o     = '0;
        grant_idx_o = 3'd0;
        any_o       = 1'b0;
        cand        = 4'd0;
        req_sh      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 4'(ptr_i) + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            req_sh = req_i >> cand;
            if (!any_o && req_sh[0]) begin
                any_o       = 1'b1;
                grant_o     = N_REQ'(1) << cand;
                grant_idx_o = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: accepts bytes from N_REQ requesters (round-robin),
// then sequences the TX datapath through load, start, 8 data and stop bits.
//
// Handshake: a byte transfers on a clk edge where req_valid[i] & req_ready[i]
// are both 1. req_ready is one-hot and only ever asserted in IDLE with
// sched_en=1; a requester holds valid and stable data until it is accepted.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FRAME_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 sched_en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 TX_en,
    output logic                 TX_Ready,
    output logic [7:0]           Word_To_Send,
    output logic                 Counter_Reset,
    output logic [3:0]           TX_Bit_sel,
    input  logic                 Count_Reached,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 tx_done,
    output logic [1:0]           state_o
);

    // First bit index of a frame (start bit); the frame counts down to the stop index
    localparam logic [3:0] START_IDX = 4'(FRAME_BITS - 1);
    localparam logic [3:0] STOP_IDX  = 4'(BIT_IDX_STOP);

    tx_state_e        state_q;
    logic [2:0]       ptr_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       word_q;
    logic [2:0]       grant_id_q;
    logic             tx_en_q;
    logic             tx_ready_q;
    logic             counter_reset_q;
    logic [3:0]       bit_sel_q;
    logic             busy_q;
    logic             tx_done_q;

    logic [N_REQ-1:0] arb_grant;
    logic [2:0]       arb_idx;
    logic             arb_any;
    logic             accept_d;
    logic [7:0]       sel_byte_d;

    uart_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .grant_o    (arb_grant),
        .grant_idx_o(arb_idx),
        .any_o      (arb_any)
    );

    // Offer the winner only while idle and scheduling is enabled
    always_comb begin
        req_ready = '0;
        accept_d  = 1'b0;
        if (state_q == IDLE && sched_en) begin
            req_ready = arb_grant;
            accept_d  = arb_any;
        end
    end

    // Pick the winning requester's byte out of the packed data bus
    always_comb begin
        sel_byte_d = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == arb_idx) begin
                sel_byte_d = req_data[8*i +: 8];
            end
        end
    end

    // Scheduler FSM with registered datapath controls
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q         <= IDLE;
            ptr_q           <= 3'd0;
            bit_cnt_q       <= 4'd0;
            word_q          <= 8'h00;
            grant_id_q      <= 3'd0;
            tx_en_q         <= 1'b0;
            tx_ready_q      <= 1'b1;
            counter_reset_q <= 1'b1;
            bit_sel_q       <= 4'd0;
            busy_q          <= 1'b0;
            tx_done_q       <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Count_Reached is ignored here: the datapath counter is held at 0
                    if (accept_d) begin
                        state_q    <= LOAD;
                        word_q     <= sel_byte_d;
                        grant_id_q <= arb_idx;
                        ptr_q      <= rr_next(arb_idx, N_REQ);
                        tx_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    // Datapath captures the frame on this edge; start bit goes out next
                    state_q         <= SEND;
                    bit_cnt_q       <= START_IDX;
                    bit_sel_q       <= START_IDX;
                    tx_en_q         <= 1'b0;
                    tx_ready_q      <= 1'b0;
                    counter_reset_q <= 1'b0;
                end
                SEND: begin
                    if (Count_Reached) begin
                        if (bit_cnt_q != STOP_IDX) begin
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                            bit_sel_q <= bit_cnt_q - 4'd1;
                        end else begin
                            // Stop bit finished: back to idle, line held at stop level
                            state_q         <= IDLE;
                            tx_done_q       <= 1'b1;
                            busy_q          <= 1'b0;
                            tx_ready_q      <= 1'b1;
                            counter_reset_q <= 1'b1;
                            bit_sel_q       <= STOP_IDX;
                        end
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    tx_en_q         <= 1'b0;
                    tx_ready_q      <= 1'b1;
                    counter_reset_q <= 1'b1;
                    bit_sel_q       <= STOP_IDX;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign TX_en         = tx_en_q;
    assign TX_Ready      = tx_ready_q;
    assign Word_To_Send  = word_q;
    assign Counter_Reset = counter_reset_q;
    assign TX_Bit_sel    = bit_sel_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign tx_done       = tx_done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small TX datapath model
// (bit-time counter and frame shifter) driving Count_Reached and RsTx.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  always #5 clk = ~clk;

  logic        sched_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        TX_en;
  logic        TX_Ready;
  logic [7:0]  Word_To_Send;
  logic        Counter_Reset;
  logic [3:0]  TX_Bit_sel;
  logic        Count_Reached;
  logic        busy;
  logic [2:0]  grant_id;
  logic        tx_done;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(.N_REQ(4), .FRAME_BITS(10)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .sched_en     (sched_en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .TX_en        (TX_en),
    .TX_Ready     (TX_Ready),
    .Word_To_Send (Word_To_Send),
    .Counter_Reset(Counter_Reset),
    .TX_Bit_sel   (TX_Bit_sel),
    .Count_Reached(Count_Reached),
    .busy         (busy),
    .grant_id     (grant_id),
    .tx_done      (tx_done),
    .state_o      (state_o)
  );

  // ---------------- datapath model ----------------
  int          bit_clk_cnt;
  logic        inject;
  logic [9:0]  frame_q;
  logic        rstx;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) bit_clk_cnt <= 0;
    else if (Counter_Reset) bit_clk_cnt <= 0;
    else if (bit_clk_cnt == CLKS_PER_BIT - 1) bit_clk_cnt <= 0;
    else bit_clk_cnt <= bit_clk_cnt + 1;
  end

  assign Count_Reached = (!Counter_Reset && bit_clk_cnt == CLKS_PER_BIT - 1) || inject;

  // frame_q[9] start, [8..1] data LSB first, [0] stop
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) frame_q <= 10'h3FF;
    else if (TX_en) begin
      frame_q[BIT_IDX_START] <= 1'b0;
      for (int i = 0; i < 8; i++) frame_q[8-i] <= Word_To_Send[i];
      frame_q[BIT_IDX_STOP] <= 1'b1;
    end
  end

  assign rstx = (TX_Bit_sel <= 4'd9) ? frame_q[TX_Bit_sel] : 1'bx;

  // ---------------- driver / check tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(IDLE));
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_tx_en"}, 32'(TX_en), 0);
    chk({tag, "_tx_ready"}, 32'(TX_Ready), 1);
    chk({tag, "_word"}, 32'(Word_To_Send), 0);
    chk({tag, "_counter_reset"}, 32'(Counter_Reset), 1);
    chk({tag, "_bit_sel"}, 32'(TX_Bit_sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_tx_done"}, 32'(tx_done), 0);
  endtask

  // Called on the accept cycle (cycle 0); returns at cycle 502 (next accept slot)
  task automatic frame(input logic [3:0] exp_ready, input logic [2:0] exp_id,
                       input logic [7:0] exp_word, input logic [3:0] drop);
    #1;
    chk("accept_ready", 32'(req_ready), 32'(exp_ready));
    step(1);
    chk("load_state", 32'(state_o), 32'(LOAD));
    chk("load_tx_en", 32'(TX_en), 1);
    chk("load_grant_id", 32'(grant_id), 32'(exp_id));
    chk("load_word", 32'(Word_To_Send), 32'(exp_word));
    chk("load_ready_low", 32'(req_ready), 0);
    req_valid = req_valid & ~drop;
    step(250);
    chk("mid_bit_sel", 32'(TX_Bit_sel), 5);
    chk("mid_ready_low", 32'(req_ready), 0);
    chk("mid_busy", 32'(busy), 1);
    step(251);
    chk("done_pulse", 32'(tx_done), 1);
    chk("done_state", 32'(state_o), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  int exp_rstx [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int done_seen;

  initial begin
    sched_en  = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    inject    = 1'b0;
    step(3);
    chk_reset_values("rst");
    reset_b = 1'b1;
    step(2);

    // Spurious Count_Reached in IDLE
    inject = 1'b1;
    step(1);
    inject = 1'b0;
    step(1);
    chk("spur_state", 32'(state_o), 32'(IDLE));
    chk("spur_bit_sel", 32'(TX_Bit_sel), 0);

    // Single request 0xA5 from requester 0
    sched_en  = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step(1);
    chk("t1_tx_en", 32'(TX_en), 1);
    chk("t1_word", 32'(Word_To_Send), 32'hA5);
    chk("t1_busy", 32'(busy), 1);
    req_valid = 4'b0000;
    step(1);
    chk("t1_tx_en_off", 32'(TX_en), 0);
    chk("t1_tx_ready_off", 32'(TX_Ready), 0);
    chk("t1_cnt_run", 32'(Counter_Reset), 0);
    for (int b = 0; b < 10; b++) begin
      chk("t1_bit_first", 32'(TX_Bit_sel), 32'(9 - b));
      chk("t1_rstx", 32'(rstx), 32'(exp_rstx[b]));
      step(49);
      chk("t1_bit_last", 32'(TX_Bit_sel), 32'(9 - b));
      step(1);
    end
    chk("t1_done", 32'(tx_done), 1);
    chk("t1_idle", 32'(state_o), 32'(IDLE));
    chk("t1_idle_bit_sel", 32'(TX_Bit_sel), 0);
    chk("t1_idle_tx_ready", 32'(TX_Ready), 1);
    step(1);
    chk("t1_done_off", 32'(tx_done), 0);
    chk("t1_word_hold", 32'(Word_To_Send), 32'hA5);

    // All four valid from reset: grants 0,1,2,3,0 every 502 cycles
    reset_b = 1'b0;
    step(2);
    reset_b   = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    frame(4'b0001, 3'd0, 8'h10, 4'b0000);
    frame(4'b0010, 3'd1, 8'h11, 4'b0000);
    frame(4'b0100, 3'd2, 8'h12, 4'b0000);
    frame(4'b1000, 3'd3, 8'h13, 4'b0000);
    frame(4'b0001, 3'd0, 8'h10, 4'b1111);
    step(1);
    chk("t2_idle", 32'(state_o), 32'(IDLE));
    chk("t2_done_off", 32'(tx_done), 0);

    // Pointer fairness: grant 2, then 0 and 3 valid -> 3 wins, then 0
    req_data  = 32'hC35A_113C;
    req_valid = 4'b0100;
    frame(4'b0100, 3'd2, 8'h5A, 4'b0100);
    req_valid = 4'b1001;
    frame(4'b1000, 3'd3, 8'hC3, 4'b1000);
    frame(4'b0001, 3'd0, 8'h3C, 4'b0001);

    // sched_en dropped at cycle 100 of a frame
    req_valid = 4'b0010;
    #1;
    chk("t4_ready", 32'(req_ready), 32'h2);
    step(1);
    chk("t4_grant", 32'(grant_id), 1);
    step(99);
    sched_en = 1'b0;
    #1;
    chk("t4_ready_mid", 32'(req_ready), 0);
    step(402);
    chk("t4_done", 32'(tx_done), 1);
    chk("t4_ready_dis", 32'(req_ready), 0);
    step(5);
    chk("t4_ready_still", 32'(req_ready), 0);
    chk("t4_idle", 32'(state_o), 32'(IDLE));
    chk("t4_busy", 32'(busy), 0);
    sched_en = 1'b1;
    #1;
    chk("t4_resume_ready", 32'(req_ready), 32'h2);
    step(1);
    chk("t4_resume_load", 32'(state_o), 32'(LOAD));
    chk("t4_resume_grant", 32'(grant_id), 1);
    req_valid = 4'b0000;

    // Asynchronous reset during data bit 4
    step(270);
    chk("t5_bit4", 32'(TX_Bit_sel), 4);
    reset_b = 1'b0;
    #1;
    chk_reset_values("t5");
    step(3);
    reset_b   = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 600; c++) begin
      step(1);
      if (tx_done === 1'b1) done_seen++;
    end
    chk("t5_no_done", 32'(done_seen), 0);
    req_valid = 4'b0001;
    frame(4'b0001, 3'd0, 8'h3C, 4'b0001);

    // Spurious Count_Reached in IDLE again, after traffic
    step(3);
    inject = 1'b1;
    step(1);
    inject = 1'b0;
    step(1);
    chk("spur2_state", 32'(state_o), 32'(IDLE));
    chk("spur2_bit_sel", 32'(TX_Bit_sel), 0);
    chk("spur2_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
